// File: rtl/oneapi_avalon_to_axi_gasket.sv
// Avalon-ST video sink to AXI4-Stream master gasket with a 2-entry skid buffer.
// Define GASKET_LINE_CHECK_EN to compile in the line-length checker driving coe_line_err.
module oneapi_avalon_to_axi_gasket #(
  parameter int PARALLEL_PIXELS      = 1,
  parameter int CHANNELS             = 3,
  parameter int BITS_PER_CHANNEL_AV  = 8,
  parameter int BITS_PER_PIXEL_AV    = 24,
  parameter int BITS_AV              = 24,
  parameter int BITS_PER_CHANNEL_AXI = 8,
  parameter int BITS_PER_PIXEL_AXI   = 24,
  parameter int BITS_AXI             = 24,
  parameter int EMPTY_BITS           = 2,
  parameter int TUSER_BITS           = 3,
  parameter int LINE_BEATS           = 1920,
  parameter logic [BITS_PER_CHANNEL_AXI-1:0] MASK_OUT = 'hff
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset,
  output logic                  asi_ready,
  input  logic                  asi_valid,
  input  logic [BITS_AV-1:0]    asi_data,
  input  logic                  asi_startofpacket,
  input  logic                  asi_endofpacket,
  input  logic [EMPTY_BITS-1:0] asi_empty,
  input  logic                  axm_tready,
  output logic                  axm_tvalid,
  output logic [BITS_AXI-1:0]   axm_tdata,
  output logic                  axm_tlast,
  output logic [TUSER_BITS-1:0] axm_tuser,
  output logic                  coe_line_err
);

  logic                out_valid, out_valid_n;
  logic [BITS_AXI-1:0] out_data, out_data_n;
  logic                out_sop, out_sop_n;
  logic                out_eop, out_eop_n;
  logic                skid_valid, skid_valid_n;
  logic [BITS_AXI-1:0] skid_data, skid_data_n;
  logic                skid_sop, skid_sop_n;
  logic                skid_eop, skid_eop_n;
  logic                ready_q;
  logic                accept;
  logic [BITS_AXI-1:0] mapped;

  assign accept = asi_valid && ready_q;

  // Remap is done on entry so the buffers hold AXI-formatted data only.
  always_comb begin
    logic [BITS_PER_CHANNEL_AXI-1:0] chan;
    mapped = '0;
    chan   = '0;
    for (int p = 0; p < PARALLEL_PIXELS; p++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        chan = '0;
        chan[BITS_PER_CHANNEL_AV-1:0] =
          asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AV];
        mapped[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AXI] =
          chan & MASK_OUT;
      end
    end
  end

  // Skid beat always has priority for the output slot so ordering is preserved.
  always_comb begin
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    out_sop_n    = out_sop;
    out_eop_n    = out_eop;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_sop_n   = skid_sop;
    skid_eop_n   = skid_eop;
    if (!out_valid || axm_tready) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_data_n   = skid_data;
        out_sop_n    = skid_sop;
        out_eop_n    = skid_eop;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        out_valid_n = 1'b1;
        out_data_n  = mapped;
        out_sop_n   = asi_startofpacket;
        out_eop_n   = asi_endofpacket;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_data_n  = mapped;
      skid_sop_n   = asi_startofpacket;
      skid_eop_n   = asi_endofpacket;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sop   <= 1'b0;
      skid_eop   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_sop    <= out_sop_n;
      out_eop    <= out_eop_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_sop   <= skid_sop_n;
      skid_eop   <= skid_eop_n;
      ready_q    <= !skid_valid_n;
    end
  end

  assign asi_ready  = ready_q;
  assign axm_tvalid = out_valid;
  assign axm_tdata  = out_data;
  assign axm_tlast  = out_eop;
  assign axm_tuser  = {{(TUSER_BITS-1){1'b0}}, out_sop};

`ifdef GASKET_LINE_CHECK_EN
  localparam int CNT_W = $clog2(LINE_BEATS + 2);

  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             line_err;

  // A sop beat always starts a fresh line, even if the previous one lacked eop.
  always_comb begin
    cnt_inc = (asi_startofpacket ? '0 : line_cnt) + CNT_W'(1);
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      line_cnt <= '0;
      line_err <= 1'b0;
    end else if (accept) begin
      if (asi_endofpacket) begin
        line_cnt <= '0;
        if (cnt_inc != CNT_W'(LINE_BEATS)) line_err <= 1'b1;
      end else if (cnt_inc >= CNT_W'(LINE_BEATS)) begin
        line_cnt <= CNT_W'(LINE_BEATS);
        line_err <= 1'b1;
      end else begin
        line_cnt <= cnt_inc;
      end
    end
  end

  assign coe_line_err = line_err;
`else
  assign coe_line_err = 1'b0;
`endif

endmodule

// File: tb/tb_oneapi_avalon_to_axi_gasket.sv
// Randomized self-checking bench for oneapi_avalon_to_axi_gasket against a queue-based model.
// Line-error expectations follow GASKET_LINE_CHECK_EN when it is defined for the build.
module tb_oneapi_avalon_to_axi_gasket;

  localparam int LB = 4;
`ifdef GASKET_LINE_CHECK_EN
  localparam bit LINE_CHECK_EN = 1'b1;
`else
  localparam bit LINE_CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        asi_ready;
  logic        asi_valid = 1'b0;
  logic [23:0] asi_data = '0;
  logic        asi_sop = 1'b0;
  logic        asi_eop = 1'b0;
  logic [1:0]  asi_empty = '0;
  logic        axm_tready = 1'b1;
  logic        axm_tvalid;
  logic [23:0] axm_tdata;
  logic        axm_tlast;
  logic [2:0]  axm_tuser;
  logic        line_err;

  logic        m_ready;
  logic        m_valid = 1'b0;
  logic [23:0] m_data = '0;
  logic        m_tvalid;
  logic [29:0] m_tdata;
  logic        m_tlast;
  logic [2:0]  m_tuser;
  logic        m_err;

  always #5 clk = ~clk;

  oneapi_avalon_to_axi_gasket #(.LINE_BEATS(LB)) u_dut (
    .csi_clk(clk), .rsi_reset(rst),
    .asi_ready(asi_ready), .asi_valid(asi_valid), .asi_data(asi_data),
    .asi_startofpacket(asi_sop), .asi_endofpacket(asi_eop), .asi_empty(asi_empty),
    .axm_tready(axm_tready), .axm_tvalid(axm_tvalid), .axm_tdata(axm_tdata),
    .axm_tlast(axm_tlast), .axm_tuser(axm_tuser), .coe_line_err(line_err)
  );

  oneapi_avalon_to_axi_gasket #(
    .BITS_PER_CHANNEL_AXI(10), .BITS_PER_PIXEL_AXI(30), .BITS_AXI(30), .MASK_OUT(10'h00f)
  ) u_dut_mask (
    .csi_clk(clk), .rsi_reset(rst),
    .asi_ready(m_ready), .asi_valid(m_valid), .asi_data(m_data),
    .asi_startofpacket(1'b1), .asi_endofpacket(1'b1), .asi_empty(2'b00),
    .axm_tready(1'b1), .axm_tvalid(m_tvalid), .axm_tdata(m_tdata),
    .axm_tlast(m_tlast), .axm_tuser(m_tuser), .coe_line_err(m_err)
  );

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t q[$];
  beat_t b;
  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_en = 1'b0;
  int    line_len = 0;
  bit    err_model = 1'b0;
  bit    prev_stall = 1'b0;
  logic [23:0] prev_data;
  logic        prev_last;
  logic [2:0]  prev_user;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Channel c of the 24-bit Avalon pixel lands at bit bpc*c, masked.
  function automatic logic [63:0] map_pix(input logic [23:0] d, input int bpc, input logic [63:0] mask);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < 3; c++)
      r = r | ((((64'(d)) >> (8*c)) & 64'hff & mask) << (bpc*c));
    return r;
  endfunction

  // Occupancy model: beats accepted but not yet delivered, in order.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("tvalid_vs_occupancy", axm_tvalid, q.size() > 0);
      checkOutput("ready_vs_occupancy", asi_ready, q.size() < 2);
      checkOutput("line_err", line_err, LINE_CHECK_EN ? err_model : 1'b0);
      if (prev_stall) begin
        checkOutput("hold_tdata", axm_tdata, prev_data);
        checkOutput("hold_tlast", axm_tlast, prev_last);
        checkOutput("hold_tuser", axm_tuser, prev_user);
      end
      if (axm_tvalid && axm_tready) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_beat", axm_tvalid, 1'b0);
        end else begin
          b = q.pop_front();
          checkOutput("tdata", axm_tdata, map_pix(b.data, 8, 64'hff));
          checkOutput("tlast", axm_tlast, b.eop);
          checkOutput("tuser", axm_tuser, {2'b00, b.sop});
        end
      end
      prev_stall = axm_tvalid && !axm_tready;
      prev_data  = axm_tdata;
      prev_last  = axm_tlast;
      prev_user  = axm_tuser;
      if (asi_valid && asi_ready) begin
        q.push_back('{asi_data, asi_sop, asi_eop});
        if (asi_sop) line_len = 0;
        line_len++;
        if (asi_eop) begin
          if (line_len != LB) err_model = 1'b1;
          line_len = 0;
        end else if (line_len >= LB) begin
          err_model = 1'b1;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset(input int cycles);
    mon_en = 1'b0;
    rst = 1'b1;
    asi_valid = 1'b0;
    axm_tready = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", axm_tvalid, 1'b0);
    checkOutput("rst_ready", asi_ready, 1'b0);
    checkOutput("rst_tdata", axm_tdata, 24'h0);
    checkOutput("rst_tlast", axm_tlast, 1'b0);
    checkOutput("rst_tuser", axm_tuser, 3'b000);
    checkOutput("rst_line_err", line_err, 1'b0);
    q.delete();
    line_len = 0;
    err_model = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  // Holds the beat on the bus until the gasket accepts it (bounded wait).
  task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
    int  guard;
    bit  acc;
    guard = 0;
    acc = 1'b0;
    asi_valid = 1'b1;
    asi_data = d;
    asi_sop = s;
    asi_eop = e;
    while (!acc) begin
      @(negedge clk);
      acc = asi_ready;
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 100) begin
        checkOutput("send_timeout", asi_ready, 1'b1);
        break;
      end
    end
    asi_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int len, input bit with_sop, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        @(posedge clk); #1;
      end
      send_beat(24'($urandom), with_sop && (i == 0), i == len - 1);
    end
  endtask

  task automatic random_lines(input int n, input bit good_only);
    bit stop;
    stop = 1'b0;
    fork
      begin
        for (int l = 0; l < n; l++)
          applyStimulus(good_only ? LB : int'($urandom_range(1, 6)), 1'($urandom % 2), 1'b1);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          axm_tready = ($urandom % 3) != 0;
        end
      end
    join
    axm_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic mask_check(input logic [23:0] d);
    m_valid = 1'b1;
    m_data = d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("mask_tvalid", m_tvalid, 1'b1);
    checkOutput("mask_tdata", m_tdata, map_pix(d, 10, 64'h00f));
    checkOutput("mask_tuser", m_tuser, 3'b001);
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset(3);

    // Directed line: latency-1 delivery with sop only on the first beat.
    send_beat(24'h112233, 1'b1, 1'b0);
    checkOutput("first_tvalid", axm_tvalid, 1'b1);
    checkOutput("first_tdata", axm_tdata, 24'h112233);
    checkOutput("first_tuser", axm_tuser, 3'b001);
    send_beat(24'h223344, 1'b0, 1'b0);
    checkOutput("second_tuser", axm_tuser, 3'b000);
    send_beat(24'h334455, 1'b0, 1'b0);
    send_beat(24'h445566, 1'b0, 1'b1);
    checkOutput("fourth_tdata", axm_tdata, 24'h445566);
    checkOutput("fourth_tlast", axm_tlast, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Continuous stream with a three-cycle downstream stall.
    fork
      begin
        applyStimulus(LB, 1'b1, 1'b0);
        applyStimulus(LB, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        axm_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_ready_low", asi_ready, 1'b0);
        checkOutput("stall_tvalid", axm_tvalid, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        axm_tready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    random_lines(10, 1'b1);
    checkOutput("good_lines_err", line_err, 1'b0);

    // Short line: eop on the third beat.
    applyStimulus(3, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("short_line_err", line_err, LINE_CHECK_EN);
    random_lines(12, 1'b0);
    checkOutput("err_sticky", line_err, LINE_CHECK_EN);

    // Fill both buffer entries, then reset mid-frame.
    axm_tready = 1'b0;
    send_beat(24'hA1A2A3, 1'b1, 1'b0);
    send_beat(24'hB1B2B3, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_ready_low", asi_ready, 1'b0);
    @(posedge clk); #1;
    do_reset(1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("no_stale_tvalid", axm_tvalid, 1'b0);
    @(posedge clk); #1;

    mask_check(24'hFFFFFF);
    mask_check(24'h123456);
    for (int i = 0; i < 3; i++) mask_check(24'($urandom));
    m_valid = 1'b0;

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
